// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
// Optional feature macro: LED_SEQ_PWM_EN (PWM dimming stage).
package led_seq_pkg;

  // Pattern modes; the encoding matches the 2-bit mode request input.
  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } led_mode_t;

  // Travel direction of the lit bit in BOUNCE mode.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Width of the free-running PWM counter and of the brightness input.
  localparam int PWM_W = 4;

endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: control inputs, LED outputs and debug state of the
// LED sequencer. The brightness signal exists only with LED_SEQ_PWM_EN.
//
// Transfer semantics: there is no valid/ready pair. div_load is a
// single-cycle strobe; div_value is captured on the rising edge where
// div_load is high and ignored otherwise. enable and mode are levels,
// and mode is only looked at on divider wrap edges. tick is a one-cycle
// pulse marking the first cycle that led shows a new pattern.
interface led_sequencer_if
  import led_seq_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int DIV_W = 24
) ();

  logic             enable;
  logic [1:0]       mode;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] brightness;
`endif
  logic [LED_W-1:0] led;
  logic             tick;
  // Debug view of the pattern state machine.
  led_mode_t        dbg_mode;
  dir_t             dbg_dir;

`ifdef LED_SEQ_PWM_EN
  modport master (output enable, mode, div_load, div_value, brightness,
                  input  led, tick, dbg_mode, dbg_dir);
  modport slave  (input  enable, mode, div_load, div_value, brightness,
                  output led, tick, dbg_mode, dbg_dir);
`else
  modport master (output enable, mode, div_load, div_value,
                  input  led, tick, dbg_mode, dbg_dir);
  modport slave  (input  enable, mode, div_load, div_value,
                  output led, tick, dbg_mode, dbg_dir);
`endif

endinterface

// File: rtl/led_prescaler.sv
// led_prescaler: programmable rate divider. Counts 0..D-1 while enabled
// (D = 0 behaves as 1) and raises wrap during the cycle whose rising edge
// is the wrap edge. A div_load strobe reloads D and restarts the count,
// suppressing any coincident wrap.
module led_prescaler #(
  parameter int               DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             wrap
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] last;
  logic             at_end;

  // Terminal count is D-1, with D = 0 clamped to 1 (terminal count 0).
  assign last   = (div_q == '0) ? '0 : (div_q - ONE);
  assign at_end = (cnt_q == last);
  assign wrap   = enable && !div_load && at_end;

  // Divider register and counter; a load restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_RESET;
      cnt_q <= '0;
    end else if (div_load) begin
      div_q <= div_value;
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= at_end ? '0 : (cnt_q + ONE);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: LED pattern generator (COUNT / ROTATE / BOUNCE / BLINK)
// advancing once per prescaler period. With LED_SEQ_PWM_EN defined, a
// PWM stage gates the pattern by brightness and adds one cycle of delay
// to both led and tick.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int               LED_W     = 16,
  parameter int               DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = 24'd10_000_000
) (
  input  logic            clock_rtl,
  input  logic            reset_rtl_0_1,
  led_sequencer_if.slave  bus
);

  localparam logic [LED_W-1:0] LSB = LED_W'(1);

  logic             wrap;
  led_mode_t        mode_q, mode_d, mode_req;
  dir_t             dir_q, dir_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic             tick_q;

  led_prescaler #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_prescaler (
    .clk       (clock_rtl),
    .rst_n     (reset_rtl_0_1),
    .enable    (bus.enable),
    .div_load  (bus.div_load),
    .div_value (bus.div_value),
    .wrap      (wrap)
  );

  assign mode_req = led_mode_t'(bus.mode);

  // Next pattern: on a wrap either reseed for a new mode or advance.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    if (wrap) begin
      if (mode_req != mode_q) begin
        mode_d = mode_req;
        case (mode_req)
          MODE_COUNT:  pat_d = '0;
          MODE_ROTATE: pat_d = LSB;
          MODE_BOUNCE: begin
            pat_d = LSB;
            dir_d = DIR_LEFT;
          end
          default:     pat_d = '1;
        endcase
      end else begin
        case (mode_q)
          MODE_COUNT:  pat_d = pat_q + LSB;
          MODE_ROTATE: pat_d = (pat_q << 1) | (pat_q >> (LED_W - 1));
          MODE_BOUNCE: begin
            // A single LED has nowhere to move, so it stays lit.
            if (LED_W > 1) begin
              if (dir_q == DIR_LEFT) begin
                pat_d = pat_q << 1;
                if (pat_d[LED_W-1]) dir_d = DIR_RIGHT;
              end else begin
                pat_d = pat_q >> 1;
                if (pat_d[0]) dir_d = DIR_LEFT;
              end
            end
          end
          default:     pat_d = ~pat_q;
        endcase
      end
    end
  end

  // Pattern state register and update pulse.
  always_ff @(posedge clock_rtl or negedge reset_rtl_0_1) begin
    if (!reset_rtl_0_1) begin
      mode_q <= MODE_COUNT;
      dir_q  <= DIR_LEFT;
      pat_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      tick_q <= wrap;
    end
  end

  assign bus.dbg_mode = mode_q;
  assign bus.dbg_dir  = dir_q;

`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_q;
  logic [LED_W-1:0] led_q;
  logic             tick_d_q;

  // PWM stage: free-running duty counter gating a registered copy of the pattern.
  always_ff @(posedge clock_rtl or negedge reset_rtl_0_1) begin
    if (!reset_rtl_0_1) begin
      pwm_q    <= '0;
      led_q    <= '0;
      tick_d_q <= 1'b0;
    end else begin
      pwm_q    <= pwm_q + 1'b1;
      led_q    <= pat_q & {LED_W{(pwm_q < bus.brightness)}};
      tick_d_q <= tick_q;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_d_q;
`else
  assign bus.led  = pat_q;
  assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and randomized checks of led_sequencer
// against a behavioural model. Builds with or without LED_SEQ_PWM_EN.
module tb_led_sequencer;
  import led_seq_pkg::*;

  localparam int               LED_W     = 16;
  localparam int               DIV_W     = 24;
  localparam logic [DIV_W-1:0] DIV_RESET = 24'd10_000_000;
  localparam logic [31:0]      MASK      = 32'((64'd1 << LED_W) - 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_sequencer_if #(.LED_W(LED_W), .DIV_W(DIV_W)) bus ();
  led_sequencer #(.LED_W(LED_W), .DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) u_dut (
    .clock_rtl     (clk),
    .reset_rtl_0_1 (rst_n),
    .bus           (bus)
  );

  // Single-LED instance, permanently in BOUNCE with D = 1.
  led_sequencer_if #(.LED_W(1), .DIV_W(DIV_W)) bus1 ();
  led_sequencer #(.LED_W(1), .DIV_W(DIV_W), .DIV_RESET(24'd1)) u_dut1 (
    .clock_rtl     (clk),
    .reset_rtl_0_1 (rst_n),
    .bus           (bus1)
  );

  // ---------------- stimulus variables ----------------
  bit     en;
  int     md;
  bit     ld;
  longint dv;
  int     br;
  bit     chk_w1;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  longint      m_div, m_cnt;
  int          m_mode, m_pos, m_step, m_pwm;
  logic [31:0] m_pat, m_led, m_w1;
  bit          m_tick, m_tick_q;

  task automatic model_reset();
    m_div = longint'(DIV_RESET); m_cnt = 0; m_mode = 0;
    m_pos = 0; m_step = 1; m_pat = 0; m_led = 0; m_tick = 0;
    m_pwm = 0; m_tick_q = 0; m_w1 = 0;
  endtask

  // One rising edge: period counting, then pattern rules, then output stage.
  task automatic model_step();
    bit          wrap = 0;
    longint      d;
    logic [31:0] old_pat = m_pat;
    int          old_pwm = m_pwm;
    bit          old_tq  = m_tick_q;
    if (ld) begin
      m_div = dv; m_cnt = 0;
    end else if (en) begin
      d = (m_div == 0) ? 1 : m_div;
      if (m_cnt == d - 1) begin m_cnt = 0; wrap = 1; end
      else m_cnt++;
    end
    if (wrap) begin
      if (md != m_mode) begin
        m_mode = md;
        case (md)
          0: m_pat = 0;
          1: m_pat = 1;
          2: begin m_pos = 0; m_step = 1; m_pat = 1; end
          default: m_pat = MASK;
        endcase
      end else begin
        case (m_mode)
          0: m_pat = (m_pat + 1) & MASK;
          1: m_pat = ((m_pat << 1) | (m_pat >> (LED_W - 1))) & MASK;
          2: begin
            m_pos += m_step;
            if (m_pos == LED_W - 1) m_step = -1;
            else if (m_pos == 0) m_step = 1;
            m_pat = 32'd1 << m_pos;
          end
          default: m_pat = ~m_pat & MASK;
        endcase
      end
    end
`ifdef LED_SEQ_PWM_EN
    m_led    = (old_pwm < br) ? old_pat : 32'd0;
    m_w1     = (old_pwm < 15) ? 32'd1 : 32'd0;
    m_tick   = old_tq;
    m_tick_q = wrap;
    m_pwm    = (m_pwm + 1) % 16;
`else
    m_led  = m_pat;
    m_w1   = 32'd1;
    m_tick = wrap;
`endif
  endtask

  // ---------------- driver ----------------
  task automatic apply();
    bus.enable    = en;
    bus.mode      = 2'(md);
    bus.div_load  = ld;
    bus.div_value = DIV_W'(dv);
`ifdef LED_SEQ_PWM_EN
    bus.brightness = 4'(br);
`endif
  endtask

  // Advance n cycles; model the edge, then compare on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      apply();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("led", 32'(bus.led), m_led);
      check("tick", 32'(bus.tick), 32'(m_tick));
      if (chk_w1) check("led_w1_bounce", 32'(bus1.led), m_w1);
    end
  endtask

  int highs;

  initial begin
    en = 0; md = 0; ld = 0; dv = 0; br = 15; chk_w1 = 0;
    apply();
    bus1.enable = 1'b1; bus1.mode = 2'd2; bus1.div_load = 1'b0; bus1.div_value = '0;
`ifdef LED_SEQ_PWM_EN
    bus1.brightness = 4'd15;
`endif
    model_reset();

    // Reset state.
    #1;
    check("reset_led", 32'(bus.led), 32'd0);
    check("reset_tick", 32'(bus.tick), 32'd0);
    check("reset_mode", 32'(bus.dbg_mode), 32'(MODE_COUNT));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // COUNT at D = 4.
    en = 1; md = 0; ld = 1; dv = 4; step(1);
    ld = 0; step(40);

    // ROTATE at D = 1: reseed then walk around the ring.
    md = 1; ld = 1; dv = 1; step(1);
    ld = 0; step(40);

    // BOUNCE at D = 1, plus the single-LED instance.
    md = 2; chk_w1 = 1; step(50);
    chk_w1 = 0;

    // Reload to D = 0 mid-period, then freeze with enable low.
    md = 0; ld = 1; dv = 8; step(1);
    ld = 0; step(3);
    ld = 1; dv = 0; step(1);
    ld = 0; step(6);
    en = 0; step(5);
    en = 1; step(4);

    // BLINK, then asynchronous reset mid-period.
    md = 3; ld = 1; dv = 8; step(1);
    ld = 0; step(21);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(bus.led), 32'd0);
    check("async_reset_tick", 32'(bus.tick), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    step(2);
    check("mode_after_reset", 32'(bus.dbg_mode), 32'(MODE_COUNT));

    // Randomized phase.
    ld = 1; dv = 3; step(1);
    ld = 0;
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 3);
      ld = ($urandom_range(0, 29) == 0);
      if (ld) dv = $urandom_range(0, 6);
      if ($urandom_range(0, 49) == 0) br = $urandom_range(0, 15);
      step(1);
    end
    ld = 0; en = 1;

`ifdef LED_SEQ_PWM_EN
    // Full-on pattern held for a long period, observed at two brightnesses.
    md = 0; ld = 1; dv = 1; step(1);
    ld = 0; step(2);
    md = 3; step(1);
    ld = 1; dv = 1000; br = 4; step(1);
    ld = 0; step(2);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (bus.led == 16'hFFFF) highs++;
    end
    check("pwm_duty_4", 32'(highs), 32'd8);
    br = 0; step(2);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (bus.led != 16'h0000) highs++;
    end
    check("pwm_duty_0", 32'(highs), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the board-bring-up designs, driving the `led` bus at a programmable, human-visible rate. It generalises the fixed 16-LED demo output to any LED count and adds four selectable pattern modes, a run-time reloadable rate divider and optional PWM dimming. It sits between the clock/reset infrastructure and the top-level wrapper's `led` pins.

## Interface
- `LED_W`, 16: number of LEDs, 1 to 32
- `DIV_W`, 24: width of the rate divider
- `DIV_RESET`, 24'd10_000_000: divider value after reset
- `clock_rtl`, in, 1: system clock. One clock; all logic is on its rising edge.
- `reset_rtl_0_1`, in, 1: asynchronous, active-low reset
- `enable`, in, 1: high lets the sequencer run; low freezes the divider count and the pattern
- `mode`, in, 2: requested pattern. 0 = COUNT, 1 = ROTATE, 2 = BOUNCE, 3 = BLINK.
- `div_load`, in, 1: single-cycle strobe that loads `div_value`
- `div_value`, in, DIV_W: new divider value
- `brightness`, in, 4: PWM duty. Present only with `LED_SEQ_PWM_EN`.
- `led`, out, LED_W: registered LED drive
- `tick`, out, 1: one-cycle pulse, coincident with every pattern update

## Operation
- Reset values: `led` = 0, `tick` = 0, divider count = 0, divider register = `DIV_RESET`, active mode = COUNT, direction = LEFT. With PWM enabled, the PWM counter = 0.
- Prescaler behaviour:
  - The counter runs 0 to D-1, where D is the divider register; D = 0 is treated as 1.
  - When the counter is at D-1 and `enable` is high, the counter wraps to 0 and the pattern advances on that edge.
- `div_load` loads the divider register and clears the counter on the same edge. It takes priority over a coincident wrap: no pattern advance happens on that edge.
- Mode handling:
  - `mode` is sampled only on wrap edges.
  - If the sampled mode differs from the active mode, the active mode updates and the pattern is reseeded instead of advanced.
  - Seeds: COUNT = 0; ROTATE = 1; BOUNCE = 1 with direction LEFT; BLINK = all ones.
- COUNT advances the pattern by +1 modulo 2^LED_W, so all ones wraps to 0.
- ROTATE rotates left by one position; bit LED_W-1 moves to bit 0.
- BOUNCE:
  - A single lit bit shifts in the current direction.
  - When the lit bit reaches LED_W-1, the direction becomes RIGHT.
  - When the lit bit reaches 0, the direction becomes LEFT.
  - The reversal happens on the same advance, so the end bits are lit for exactly one period.
  - With LED_W = 1 the pattern stays at 1.
- BLINK inverts every bit of the pattern.
- `enable` low holds the count, the pattern and the direction. `div_load` is still honoured while `enable` is low.
- Reset asserted mid-operation returns every register to its reset value asynchronously. Operation resumes with a full D-cycle period after reset is released.

## Timing
- `led` and `tick` are registered, and no input has a combinational path to an output.
- Pattern period is exactly D cycles while `enable` is high. The first advance after reset comes D cycles after the first enabled edge.
- `tick` is high for the single cycle in which `led` first shows the new pattern.
- A `mode` change lands on the next wrap. Latency is 1 to D cycles, depending on where the counter is when `mode` changes.
- `div_load` at cycle t gives the next wrap at cycle t+D_new.

## Configuration
- Macro: `LED_SEQ_PWM_EN`.
- Defined:
  - The `brightness` port exists.
  - A free-running 4-bit PWM counter cycles 0 to 15.
  - `led` = pattern AND (pwm_cnt < brightness), registered, so there is one extra cycle of latency.
  - `brightness` = 0 turns all LEDs off; 15 gives a 15/16 duty.
  - `tick` is delayed one cycle as well, so it stays aligned with `led`.
- Undefined: the `brightness` port and the PWM counter are absent, and `led` = pattern.

## Structure
- Package `led_seq_pkg` holds:
  - the mode enum `led_mode_t` (COUNT, ROTATE, BOUNCE, BLINK);
  - the direction enum `dir_t`;
  - the 4-bit PWM width constant.
- Sub-module `led_prescaler` holds the divider register, the counter, `div_load` handling and the zero-to-one clamp, and outputs a one-cycle `wrap` pulse.
- The pattern state machine and the PWM stage stay in `led_sequencer`.

## Test plan
All scenarios use LED_W = 16 unless stated otherwise.
- Reset, then D = 4, COUNT, enable -> `led` reads 0x0000, 0x0001, 0x0002 at 4-cycle spacing, with `tick` high exactly on each change. After 0xFFFF the next value is 0x0000.
- ROTATE with D = 1 -> `led` goes 0x0001 (reseed), 0x0002, …, 0x8000, then back to 0x0001.
- BOUNCE with D = 1 -> `led` goes 0x0001 up to 0x8000, then 0x4000, continuing down to 0x0001, then 0x0002. No end value is repeated. Repeat with LED_W = 1: `led` stays 1.
- `div_load` with `div_value` = 0 in the middle of a D = 8 period -> no advance on the load edge, then `tick` every cycle. Dropping `enable` for 5 cycles freezes `led` and `tick`.
- Assert `reset_rtl_0_1` low asynchronously mid-period while in BLINK -> `led` = 0 and `tick` = 0 immediately. The active mode is COUNT after release.
- With `LED_SEQ_PWM_EN` defined, brightness = 4, pattern 0xFFFF -> `led` is high 4 out of every 16 cycles. Brightness = 0 keeps `led` at 0.
